barrel_rshift8_pipe: RTL and testbench

- Pipelined 8-bit right barrel shifter; the right-direction counterpart of the existing left-shift barrel stages.
- Three registered stages, shifting by 4, 2, then 1 under control of the shift-amount bits.
- Supports logical, arithmetic and rotate-right modes.
- Valid/ready handshake on input and output, so it can sit between streaming producer/consumer blocks in the datapath.

---
 rtl/barrel_rshift8_pipe.sv | 134 +++++++++++++
 tb/tb_barrel_rshift8_pipe.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/barrel_rshift8_pipe.sv
// rtl/barrel_rshift8_pipe.sv - 3-stage pipelined 8-bit right barrel shifter (logical/arithmetic/rotate), valid/ready
// Optional: define RSHIFT_STICKY_EN to add the 'sticky' output (OR of bits shifted out in logical/arithmetic modes).
module barrel_rshift8_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I,
    input  logic [2:0]       S,
    input  logic [1:0]       M,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] O,
    output logic             out_valid,
`ifdef RSHIFT_STICKY_EN
    output logic             sticky,
`endif
    input  logic             out_ready
);

    // Stage shift distances: 4, 2, 1 for the 8-bit, 3-stage build.
    localparam int SH1 = 1 << (STAGES - 1);
    localparam int SH2 = SH1 >> 1;
    localparam int SH3 = SH2 >> 1;

    // Right shift by a fixed distance; mode 11 falls through to logical.
    function automatic logic [WIDTH-1:0] shr(input logic [WIDTH-1:0] d, input int n,
                                             input logic [1:0] m, input logic sign);
        logic [WIDTH-1:0] ones;
        ones = '1;
        case (m)
            2'b10:   shr = (d >> n) | (d << (WIDTH - n));
            2'b01:   shr = (d >> n) | (sign ? ~(ones >> n) : '0);
            default: shr = d >> n;
        endcase
    endfunction

`ifdef RSHIFT_STICKY_EN
    // OR of the bits that fall off the LSB end; rotate never loses bits.
    function automatic logic lost(input logic [WIDTH-1:0] d, input int n, input logic [1:0] m);
        logic [WIDTH-1:0] ones;
        ones = '1;
        lost = (m == 2'b10) ? 1'b0 : |(d & ~(ones << n));
    endfunction
`endif

    logic             adv;
    logic             v1, v2;
    logic [WIDTH-1:0] d1, d2;
    logic [1:0]       s1;
    logic             s2;
    logic [1:0]       m1, m2;
    logic             sg1, sg2;
`ifdef RSHIFT_STICKY_EN
    logic             st1, st2;
`endif

    // Whole pipe advances together; bubbles are not collapsed.
    always_comb begin
        adv      = !out_valid || out_ready;
        in_ready = adv;
    end

    // Stage 1: capture on accept, shift by 4 when S[2]; keep sign of I for arithmetic fill.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1  <= 1'b0;
            d1  <= '0;
            s1  <= '0;
            m1  <= '0;
            sg1 <= 1'b0;
`ifdef RSHIFT_STICKY_EN
            st1 <= 1'b0;
`endif
        end else if (adv) begin
            v1 <= in_valid;
            if (in_valid) begin
                d1  <= S[2] ? shr(I, SH1, M, I[WIDTH-1]) : I;
                s1  <= S[1:0];
                m1  <= M;
                sg1 <= I[WIDTH-1];
`ifdef RSHIFT_STICKY_EN
                st1 <= S[2] ? lost(I, SH1, M) : 1'b0;
`endif
            end
        end
    end

    // Stage 2: shift by 2 when the residual S[1] is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            v2  <= 1'b0;
            d2  <= '0;
            s2  <= 1'b0;
            m2  <= '0;
            sg2 <= 1'b0;
`ifdef RSHIFT_STICKY_EN
            st2 <= 1'b0;
`endif
        end else if (adv) begin
            v2 <= v1;
            if (v1) begin
                d2  <= s1[1] ? shr(d1, SH2, m1, sg1) : d1;
                s2  <= s1[0];
                m2  <= m1;
                sg2 <= sg1;
`ifdef RSHIFT_STICKY_EN
                st2 <= st1 | (s1[1] ? lost(d1, SH2, m1) : 1'b0);
`endif
            end
        end
    end

    // Stage 3: shift by 1 when S[0]; O only changes on valid results so it stays 0 until the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            O         <= '0;
`ifdef RSHIFT_STICKY_EN
            sticky    <= 1'b0;
`endif
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                O      <= s2 ? shr(d2, SH3, m2, sg2) : d2;
`ifdef RSHIFT_STICKY_EN
                sticky <= st2 | (s2 ? lost(d2, SH3, m2) : 1'b0);
`endif
            end
        end
    end

endmodule

// File: tb/tb_barrel_rshift8_pipe.sv
// tb/tb_barrel_rshift8_pipe.sv - self-checking bench for barrel_rshift8_pipe with a scoreboard reference model
module tb_barrel_rshift8_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] I;
    logic [2:0] S;
    logic [1:0] M;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] O;
    logic       out_valid;
    logic       out_ready;
`ifdef RSHIFT_STICKY_EN
    logic       sticky;
`endif

    barrel_rshift8_pipe #(.WIDTH(8), .STAGES(3)) dut (
        .clk(clk), .rst(rst), .I(I), .S(S), .M(M),
        .in_valid(in_valid), .in_ready(in_ready),
        .O(O), .out_valid(out_valid),
`ifdef RSHIFT_STICKY_EN
        .sticky(sticky),
`endif
        .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] o;
        logic       st;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   out_cyc[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc      = 0;
    logic acc;
    logic chk_lat  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: rotate via doubled word, arithmetic via signed shift, logical via plain shift.
    function automatic logic [7:0] ref_o(input logic [7:0] i, input logic [2:0] s, input logic [1:0] m);
        logic [15:0] w;
        w = {i, i};
        case (m)
            2'b01:   ref_o = 8'($signed(i) >>> s);
            2'b10:   ref_o = w[s +: 8];
            default: ref_o = i >> s;
        endcase
    endfunction

    function automatic logic ref_st(input logic [7:0] i, input logic [2:0] s, input logic [1:0] m);
        ref_st = (m != 2'b10) && ((int'(i) % (1 << s)) != 0);
    endfunction

    // One cycle: drive, observe before the edge, score, then move to the next falling edge.
    task automatic tick(input logic iv, input logic [7:0] i, input logic [2:0] s,
                        input logic [1:0] m, input logic ordy);
        in_valid = iv; I = i; S = s; M = m; out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                check("o", O, q[0].o);
`ifdef RSHIFT_STICKY_EN
                check("sticky", sticky, q[0].st);
`endif
                if (!ordy) check("stall_in_ready", in_ready, 0);
                else begin
                    if (chk_lat) check("latency", cyc - q[0].cyc, 3);
                    out_cyc.push_back(cyc);
                    void'(q.pop_front());
                end
            end
        end
        if (acc) q.push_back('{ref_o(i, s, m), ref_st(i, s, m), cyc});
        @(negedge clk);
        cyc++;
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && q.size() != 0; k++) tick(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);
        check("drain_empty", q.size(), 0);
    endtask

    // Directed single transfer with explicit latency measurement and constant expectation.
    task automatic single(input logic [7:0] i, input logic [2:0] s, input logic [1:0] m,
                          input logic [7:0] exp);
        int lat;
        in_valid = 1'b1; I = i; S = s; M = m; out_ready = 1'b1;
        #1;
        check("single_in_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
        check("single_latency", lat, 3);
        check("single_o", O, exp);
`ifdef RSHIFT_STICKY_EN
        check("single_sticky", sticky, ref_st(i, s, m));
`endif
        @(negedge clk);
    endtask

    initial begin
        logic       pv;
        logic [7:0] pi;
        logic [2:0] ps;
        logic [1:0] pm;
        int         idx;

        rst = 1'b1; in_valid = 1'b0; I = '0; S = '0; M = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_o", O, 8'h00);
        check("reset_in_ready", in_ready, 1);
        @(negedge clk);

        single(8'hB4, 3'd3, 2'b00, 8'h16);
        single(8'h96, 3'd2, 2'b01, 8'hE5);
        single(8'h96, 3'd7, 2'b01, 8'hFF);
        single(8'h56, 3'd7, 2'b01, 8'h00);
        single(8'h81, 3'd1, 2'b10, 8'hC0);
        single(8'h81, 3'd4, 2'b10, 8'h18);
        single(8'h81, 3'd7, 2'b10, 8'h03);
        for (int mm = 0; mm < 4; mm++) single(8'hA5, 3'd0, 2'(mm), 8'hA5);
        single(8'hB4, 3'd3, 2'b11, 8'h16);

        // Back-to-back streaming of FF shifted by 0..7.
        out_cyc.delete();
        chk_lat = 1'b1;
        for (int k = 0; k < 8; k++) tick(1'b1, 8'hFF, 3'(k), 2'b00, 1'b1);
        drain();
        chk_lat = 1'b0;
        check("stream_count", out_cyc.size(), 8);
        if (out_cyc.size() == 8) check("stream_contiguous", out_cyc[7] - out_cyc[0], 7);

        // Backpressure: stall 4 cycles once the first result shows up.
        idx = 0;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1, 8'(8'hC3 + idx * 17), 3'(idx + 1), 2'(idx % 3), 1'b1);
            if (acc) idx++;
        end
        #1;
        check("bp_first_valid", out_valid, 1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, 8'(8'hC3 + idx * 17), 3'(idx + 1), 2'(idx % 3), 1'b0);
            check("bp_no_accept", acc, 0);
            if (acc) idx++;
        end
        for (int k = 0; k < 20 && idx < 6; k++) begin
            tick(1'b1, 8'(8'hC3 + idx * 17), 3'(idx + 1), 2'(idx % 3), 1'b1);
            if (acc) idx++;
        end
        drain();

        // Reset with three items in flight.
        for (int k = 0; k < 3; k++) tick(1'b1, 8'(8'h5A + k), 3'(k + 2), 2'b01, 1'b1);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_o", O, 8'h00);
        check("midrst_in_ready", in_ready, 1);
        rst = 1'b0;
        q.delete();
        for (int k = 0; k < 6; k++) tick(1'b0, 8'h00, 3'd0, 2'd0, 1'b1);

        // Randomized traffic with random backpressure; producer holds until accepted.
        pv = 1'b0; pi = '0; ps = '0; pm = '0;
        for (int n = 0; n < 400; n++) begin
            if (!pv) begin
                pv = 1'($urandom_range(0, 1));
                pi = 8'($urandom);
                ps = 3'($urandom_range(0, 7));
                pm = 2'($urandom_range(0, 3));
            end
            tick(pv, pi, ps, pm, $urandom_range(0, 3) != 0);
            if (acc) pv = 1'b0;
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
